fetch_queue: RTL and testbench

//   Instruction fetch queue sitting between the IF stage and ID stage. It consumes the fetch
//   PC and instruction produced each cycle by IF, and buffers up to DEPTH {pc, instr} pairs.
//   ID pops the entries in order; the ID freeze holds the head entry. A branch flush empties
//   the queue. A sticky end-of-program flag is raised once a fetched PC passes PC_LIMIT.

---
 rtl/fetch_queue.sv | 105 ++++++++++
 tb/tb_fetch_queue.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// IF->ID fetch queue: DEPTH-entry {pc, instr} FIFO with flush, freeze and end-of-program flag.
// Define FETCH_QUEUE_BYPASS_EN for a same-cycle write-to-read path when empty.
module fetch_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter logic [ADDR_W-1:0] PC_LIMIT = 164
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_valid,
  output logic                       wr_ready,
  input  logic [ADDR_W-1:0]          wr_pc,
  input  logic [DATA_W-1:0]          wr_instr,
  input  logic                       flush,
  input  logic                       freeze,
  output logic                       rd_valid,
  output logic [ADDR_W-1:0]          rd_pc,
  output logic [DATA_W-1:0]          rd_instr,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       end_prog
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [ADDR_W-1:0] pc_mem [DEPTH];
  logic [DATA_W-1:0] in_mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;

  logic empty;
  logic full;
  logic byp;
  logic push;
  logic pop;
  logic store;
  logic deq;

  assign empty = (count == '0);
  assign full = (count == CW'(DEPTH));
  assign wr_ready = ~full;

`ifdef FETCH_QUEUE_BYPASS_EN
  assign byp = empty & wr_valid;
`else
  assign byp = 1'b0;
`endif

  assign rd_valid = ~empty | byp;
  assign push = wr_valid & wr_ready & ~flush;
  assign pop = rd_valid & ~freeze & ~flush;
  // A bypassed entry consumed in the same cycle never touches storage.
  assign store = push & ~(byp & pop);
  assign deq = pop & ~empty;

  always_comb begin
    rd_pc = '0;
    rd_instr = '0;
    if (!empty) begin
      rd_pc = pc_mem[rd_ptr];
      rd_instr = in_mem[rd_ptr];
    end else if (byp) begin
      rd_pc = wr_pc;
      rd_instr = wr_instr;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      end_prog <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i] <= '0;
        in_mem[i] <= '0;
      end
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count <= '0;
      end else begin
        if (store) begin
          pc_mem[wr_ptr] <= wr_pc;
          in_mem[wr_ptr] <= wr_instr;
          wr_ptr <= wr_ptr + PW'(1);
        end
        if (deq) begin
          rd_ptr <= rd_ptr + PW'(1);
        end
        if (store && !deq) begin
          count <= count + CW'(1);
        end else if (deq && !store) begin
          count <= count - CW'(1);
        end
      end
      if (push && (wr_pc > PC_LIMIT)) begin
        end_prog <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with a scoreboard queue of expected head PCs.
// Covers both builds via FETCH_QUEUE_BYPASS_EN.
module tb_fetch_queue;

  localparam int DEPTH = 4;
  localparam logic [31:0] LIMIT = 32'd164;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_valid;
  logic        wr_ready;
  logic [31:0] wr_pc;
  logic [31:0] wr_instr;
  logic        flush;
  logic        freeze;
  logic        rd_valid;
  logic [31:0] rd_pc;
  logic [31:0] rd_instr;
  logic [2:0]  count;
  logic        end_prog;

  int total = 0;
  int bad = 0;
  logic [31:0] sb[$];
  logic endp = 1'b0;

  always #5 clk = ~clk;

  fetch_queue #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32), .PC_LIMIT(LIMIT)) dut (
    .clk(clk),
    .rst(rst),
    .wr_valid(wr_valid),
    .wr_ready(wr_ready),
    .wr_pc(wr_pc),
    .wr_instr(wr_instr),
    .flush(flush),
    .freeze(freeze),
    .rd_valid(rd_valid),
    .rd_pc(rd_pc),
    .rd_instr(rd_instr),
    .count(count),
    .end_prog(end_prog)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle, check pre-edge outputs against the model, then advance.
  task automatic tick(input logic v, input logic [31:0] pc, input logic fl, input logic fz);
    logic byp;
    logic mpush;
    logic mpop;
    logic hv;
    logic [31:0] hp;
    wr_valid = v;
    wr_pc = pc;
    wr_instr = ~pc;
    flush = fl;
    freeze = fz;
    #1;
    byp = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
    byp = (sb.size() == 0) && v;
`endif
    hv = (sb.size() > 0) || byp;
    hp = (sb.size() > 0) ? sb[0] : (byp ? pc : 32'd0);
    chk("rd_valid", 32'(rd_valid), 32'(hv));
    chk("count", 32'(count), 32'(sb.size()));
    chk("wr_ready", 32'(wr_ready), 32'(sb.size() < DEPTH));
    chk("end_prog", 32'(end_prog), 32'(endp));
    chk("rd_pc", rd_pc, hp);
    chk("rd_instr", rd_instr, hv ? ~hp : 32'd0);
    mpop = hv && !fz && !fl;
    mpush = v && (sb.size() < DEPTH) && !fl;
    if (mpush && pc > LIMIT) endp = 1'b1;
    if (!(byp && mpop)) begin
      if (mpop) sb.pop_front();
      if (mpush) sb.push_back(pc);
    end
    if (fl) sb.delete();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    wr_valid = 1'b0;
    flush = 1'b0;
    freeze = 1'b0;
    rst = 1'b0;
    #2;
    sb.delete();
    endp = 1'b0;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_wr_ready", 32'(wr_ready), 32'd1);
    chk("rst_end_prog", 32'(end_prog), 32'd0);
    chk("rst_rd_pc", rd_pc, 32'd0);
    chk("rst_rd_instr", rd_instr, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    wr_valid = 1'b0;
    wr_pc = '0;
    wr_instr = '0;
    flush = 1'b0;
    freeze = 1'b0;
    #12;
    do_reset();

    // fill while frozen, then drain in order
    for (int i = 0; i < 4; i++) tick(1'b1, 32'(i * 4), 1'b0, 1'b1);
    tick(1'b0, 0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) tick(1'b0, 0, 1'b0, 1'b0);

    // full with pop: push blocked
    for (int i = 0; i < 4; i++) tick(1'b1, 32'(32 + i * 4), 1'b0, 1'b1);
    tick(1'b1, 32'd96, 1'b0, 1'b0);
    tick(1'b0, 0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) tick(1'b0, 0, 1'b0, 1'b0);

    // freeze holds head
    tick(1'b1, 32'd48, 1'b0, 1'b1);
    tick(1'b1, 32'd52, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) tick(1'b0, 0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) tick(1'b0, 0, 1'b0, 1'b0);

    // flush with concurrent write
    for (int i = 0; i < 3; i++) tick(1'b1, 32'(i * 4), 1'b0, 1'b1);
    tick(1'b1, 32'd16, 1'b1, 1'b0);
    tick(1'b0, 0, 1'b0, 1'b0);
    tick(1'b1, 32'd20, 1'b0, 1'b1);
    tick(1'b0, 0, 1'b0, 1'b0);
    tick(1'b0, 0, 1'b0, 1'b0);

    // end_prog threshold, flush and reset behaviour
    tick(1'b1, 32'd164, 1'b0, 1'b1);
    tick(1'b0, 0, 1'b0, 1'b1);
    tick(1'b1, 32'd168, 1'b0, 1'b1);
    tick(1'b0, 0, 1'b1, 1'b1);
    tick(1'b0, 0, 1'b0, 1'b0);
    tick(1'b1, 32'd200, 1'b1, 1'b0);
    tick(1'b0, 0, 1'b0, 1'b0);
    do_reset();
    for (int i = 0; i < 4; i++) tick(1'b1, 32'(i * 8), 1'b0, 1'b1);
    tick(1'b1, 32'd200, 1'b0, 1'b1);
    tick(1'b0, 0, 1'b0, 1'b1);

    // reset mid-traffic with a full queue
    do_reset();
    tick(1'b0, 0, 1'b0, 1'b0);

    // empty-queue write with freeze=0 (bypass build consumes it in place)
    tick(1'b1, 32'd40, 1'b0, 1'b0);
    tick(1'b0, 0, 1'b0, 1'b0);
    tick(1'b1, 32'd44, 1'b0, 1'b0);
    tick(1'b1, 32'd48, 1'b0, 1'b0);
    tick(1'b0, 0, 1'b0, 1'b0);
    tick(1'b0, 0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
